// File: rtl/mux_scan_pkg.sv
// Shared constants and types for the 16-channel mux scanner.
// Imported by the channel finder and the scan controller.
package mux_scan_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

endpackage

// File: rtl/scan_next_chan.sv
// Combinational priority finder: the next enabled channel above cur,
// or the lowest enabled channel when from_start is set.
module scan_next_chan
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             from_start,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);

    logic [N_CH-1:0] cand;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
            assign cand[gi] = mask[gi] && (from_start || (SEL_W'(gi) > cur));
        end
    endgenerate

    // Walk downwards so the lowest candidate wins.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequences a 16:1 bit mux through every enabled channel, settles, samples,
// and publishes the assembled 16-bit snapshot with a one-cycle done pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] mask,
    input  logic        mux_out,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] data
);

    localparam state_t ENTRY_STATE =
        state_t'((SETTLE == 0) ? S_SAMPLE : S_SETTLE);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic [N_CH-1:0]    shadow_q, shadow_d;
    logic [N_CH-1:0]    data_q, data_d;
    logic               done_q, done_d;

    logic [N_CH-1:0]    find_mask;
    logic               find_from_start;
    logic [SEL_W-1:0]   find_nxt;
    logic               find_found;
    logic [N_CH-1:0]    captured;

    // In IDLE the finder looks at the live mask so sel can be loaded at the
    // accepting edge; during a scan it walks the latched copy.
    assign find_from_start = (state_q == S_IDLE);
    assign find_mask       = find_from_start ? mask : mask_q;

    scan_next_chan u_next (
        .mask       (find_mask),
        .cur        (sel_q),
        .from_start (find_from_start),
        .nxt        (find_nxt),
        .found      (find_found)
    );

    assign captured = shadow_q | ({{(N_CH-1){1'b0}}, mux_out} << sel_q);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d   = mask;
                    shadow_d = '0;
                    if (find_found) begin
                        sel_d   = find_nxt;
                        cnt_d   = CNT_LOAD;
                        state_d = ENTRY_STATE;
                    end else begin
                        data_d = '0;
                        done_d = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                shadow_d = captured;
                if (find_found) begin
                    sel_d   = find_nxt;
                    cnt_d   = CNT_LOAD;
                    state_d = ENTRY_STATE;
                end else begin
                    data_d  = captured;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: three instances (SETTLE=1,2,0), each
// fed by a modelled 16:1 mux, driven from a vector table plus corner sequences.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i [3];
    logic [15:0] mask_i  [3];
    logic [15:0] in_v    [3];
    logic        mux_o   [3];
    logic [3:0]  sel_o   [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic [15:0] data_o  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 2 : 0);
            assign mux_o[gi] = in_v[gi][sel_o[gi]];
            mux_scan_ctrl #(.SETTLE(ST)) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (start_i[gi]),
                .mask    (mask_i[gi]),
                .mux_out (mux_o[gi]),
                .sel     (sel_o[gi]),
                .busy    (busy_o[gi]),
                .done    (done_o[gi]),
                .data    (data_o[gi])
            );
        end
    endgenerate

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One scan on instance d; checks latency, busy width, sel sequence,
    // data stability during the scan, result, and single-cycle done.
    task automatic run_vec(input int d, input logic [15:0] m, input logic [15:0] in,
                           input logic [15:0] exp_d, input int exp_lat);
        int ch [16];
        int k = 0;
        int n = 0;
        int busy_n = 0;
        int j;
        int st = settle_of(d);
        logic sel_ok = 1'b1;
        logic data_ok = 1'b1;
        logic [15:0] prev;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                ch[k] = i;
                k++;
            end
        end
        @(negedge clk);
        prev = data_o[d];
        in_v[d] = in;
        mask_i[d] = m;
        start_i[d] = 1'b1;
        @(posedge clk);
        #1;
        start_i[d] = 1'b0;
        while (!done_o[d] && n < 600) begin
            if (busy_o[d]) busy_n++;
            j = n / (st + 1);
            if (j >= k || int'(sel_o[d]) != ch[j]) sel_ok = 1'b0;
            if (data_o[d] != prev) data_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        $display("scan d=%0d mask=%h in=%h lat=%0d data=%h", d, m, in, n, data_o[d]);
        chk("latency", n, exp_lat);
        chk("busy_cycles", busy_n, exp_lat);
        chk("busy_low_at_done", busy_o[d], 1'b0);
        chk("data", data_o[d], exp_d);
        chk("sel_sequence", sel_ok, 1'b1);
        chk("data_stable", data_ok, 1'b1);
        @(posedge clk);
        #1;
        chk("done_single", done_o[d], 1'b0);
    endtask

    typedef struct {
        int          d;
        logic [15:0] m;
        logic [15:0] in;
        logic [15:0] exp_d;
        int          lat;
    } vec_t;

    vec_t tv [8];

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            start_i[i] = 1'b0;
            mask_i[i]  = '0;
            in_v[i]    = '0;
        end

        tv[0] = '{0, 16'hFFFF, 16'hA5C3, 16'hA5C3, 32};
        tv[1] = '{1, 16'h8001, 16'hFFFF, 16'h8001, 6};
        tv[2] = '{0, 16'h0000, 16'hFFFF, 16'h0000, 0};
        tv[3] = '{2, 16'hFFFF, 16'h1234, 16'h1234, 16};
        tv[4] = '{0, 16'h0F0F, 16'h3C3C, 16'h0C0C, 16};
        tv[5] = '{1, 16'h0400, 16'h0400, 16'h0400, 3};
        tv[6] = '{2, 16'hAAAA, 16'hFFFF, 16'hAAAA, 8};
        tv[7] = '{1, 16'h0000, 16'hFFFF, 16'h0000, 0};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_sel", sel_o[d], 4'h0);
            chk("reset_busy", busy_o[d], 1'b0);
            chk("reset_done", done_o[d], 1'b0);
            chk("reset_data", data_o[d], 16'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(tv[i].d, tv[i].m, tv[i].in, tv[i].exp_d, tv[i].lat);
        end

        // Start during a scan is ignored; start in the done cycle chains.
        @(negedge clk);
        in_v[0] = 16'hA5C3;
        mask_i[0] = 16'hFFFF;
        start_i[0] = 1'b1;
        @(posedge clk);
        #1;
        start_i[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        mask_i[0] = 16'h00FF;
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        n = 0;
        while (!done_o[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        $display("midscan start ignored: data=%h", data_o[0]);
        chk("midscan_done_seen", done_o[0], 1'b1);
        chk("midscan_data", data_o[0], 16'hA5C3);
        mask_i[0] = 16'h000F;
        start_i[0] = 1'b1;
        @(posedge clk);
        #1;
        start_i[0] = 1'b0;
        chk("b2b_busy", busy_o[0], 1'b1);
        chk("b2b_done_low", done_o[0], 1'b0);
        chk("b2b_sel", sel_o[0], 4'h0);
        n = 0;
        while (!done_o[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        $display("back-to-back scan: lat=%0d data=%h", n, data_o[0]);
        chk("b2b_latency", n, 8);
        chk("b2b_data", data_o[0], 16'h0003);

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        in_v[0] = 16'hFFFF;
        mask_i[0] = 16'hFFFF;
        start_i[0] = 1'b1;
        @(posedge clk);
        #1;
        start_i[0] = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("midscan reset: sel=%h busy=%b data=%h", sel_o[0], busy_o[0], data_o[0]);
        chk("arst_sel", sel_o[0], 4'h0);
        chk("arst_busy", busy_o[0], 1'b0);
        chk("arst_done", done_o[0], 1'b0);
        chk("arst_data", data_o[0], 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
